mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-core arbiter in front of a single data memory. The grant is
//            combinational in the request cycle. An uncontended request is
//            granted. A contended request is resolved by a round-robin pointer.
//            A core may lock ownership for up to LOCK_TIMEOUT consecutive
//            cycles. Read data is registered per core, with a one-cycle valid
//            pulse. Each core has a saturating access counter.
// Ports    : Clk, Reset_n (async, active-low)
//            Ck_Address/WriteData/MemRead/MemWrite/HalfControl/ByteControl/Lock
//                                  core k request (k = 0, 1)
//            Ck_Stall              core k request not served this cycle
//            Ck_ReadData/ReadValid registered read return for core k
//            Ck_AccessCount        saturating count of granted accesses
//            EX_MEM_*              granted request forwarded to data memory
//            MEM_ReadData          combinational read data from data memory
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int LOCK_TIMEOUT = 15
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] C0_Address,
    input  logic [31:0] C0_WriteData,
    input  logic        C0_MemRead,
    input  logic        C0_MemWrite,
    input  logic        C0_HalfControl,
    input  logic        C0_ByteControl,
    input  logic        C0_Lock,
    output logic        C0_Stall,
    output logic [31:0] C0_ReadData,
    output logic        C0_ReadValid,
    output logic [15:0] C0_AccessCount,
    input  logic [31:0] C1_Address,
    input  logic [31:0] C1_WriteData,
    input  logic        C1_MemRead,
    input  logic        C1_MemWrite,
    input  logic        C1_HalfControl,
    input  logic        C1_ByteControl,
    input  logic        C1_Lock,
    output logic        C1_Stall,
    output logic [31:0] C1_ReadData,
    output logic        C1_ReadValid,
    output logic [15:0] C1_AccessCount,
    output logic [31:0] EX_MEM_Address,
    output logic [31:0] EX_MEM_WriteData,
    output logic        EX_MEM_MemRead,
    output logic        EX_MEM_MemWrite,
    output logic        EX_MEM_HalfControl,
    output logic        EX_MEM_ByteControl,
    input  logic [31:0] MEM_ReadData
);

    localparam logic [1:0]  c_ST_IDLE    = 2'd0;
    localparam logic [1:0]  c_ST_OWN0    = 2'd1;
    localparam logic [1:0]  c_ST_OWN1    = 2'd2;
    localparam logic [4:0]  c_HOLD_LIMIT = 5'(LOCK_TIMEOUT);
    localparam logic [15:0] c_CNT_MAX    = 16'hFFFF;

    // Per-core request fields gathered into vectors indexed by core number
    logic [1:0]        w_rd_strobe;
    logic [1:0]        w_wr_strobe;
    logic [1:0]        w_lock;
    logic [1:0]        w_req;
    logic [1:0]        w_win;
    logic [1:0]        w_rd_grant;
    logic [1:0]        w_stall;
    logic              w_idle;
    logic              w_contended;
    logic [4:0]        w_hold_inc;
    logic              w_timeout;

    logic [1:0]        r_state;
    logic              r_ptr;
    logic [3:0]        r_hold;
    logic [1:0][31:0]  r_read_data;
    logic [1:0]        r_read_valid;
    logic [1:0][15:0]  r_access_cnt;

    assign w_rd_strobe = {C1_MemRead,  C0_MemRead};
    assign w_wr_strobe = {C1_MemWrite, C0_MemWrite};
    assign w_lock      = {C1_Lock,     C0_Lock};
    assign w_req       = w_rd_strobe | w_wr_strobe;

    assign w_idle      = (r_state == c_ST_IDLE);
    assign w_contended = w_idle & w_req[0] & w_req[1];

    // An owner excludes the other core even when the owner is not requesting
    assign w_win[0] = w_req[0] & ((r_state == c_ST_OWN0) | (w_idle & (~w_req[1] | ~r_ptr)));
    assign w_win[1] = w_req[1] & ((r_state == c_ST_OWN1) | (w_idle & (~w_req[0] |  r_ptr)));

    // Both strobes high counts as a write, so it never returns read data
    assign w_rd_grant = w_win & w_rd_strobe & ~w_wr_strobe;

    // Reset gates only the outputs; the grant terms feeding the flops stay
    // free of Reset_n because the flops are already held by the async clear.
    assign w_stall  = {2{Reset_n}} & w_req & ~w_win;
    assign C0_Stall = w_stall[0];
    assign C1_Stall = w_stall[1];

    // Release when the owner's next cycle would be number LOCK_TIMEOUT + 1
    assign w_hold_inc = {1'b0, r_hold} + 5'd1;
    assign w_timeout  = (w_hold_inc == c_HOLD_LIMIT);

    always_comb begin
        EX_MEM_Address     = '0;
        EX_MEM_WriteData   = '0;
        EX_MEM_MemRead     = 1'b0;
        EX_MEM_MemWrite    = 1'b0;
        EX_MEM_HalfControl = 1'b0;
        EX_MEM_ByteControl = 1'b0;
        if (Reset_n && w_win[0]) begin
            EX_MEM_Address     = C0_Address;
            EX_MEM_WriteData   = C0_WriteData;
            EX_MEM_MemRead     = C0_MemRead & ~C0_MemWrite;
            EX_MEM_MemWrite    = C0_MemWrite;
            EX_MEM_HalfControl = C0_HalfControl;
            EX_MEM_ByteControl = C0_ByteControl;
        end else if (Reset_n && w_win[1]) begin
            EX_MEM_Address     = C1_Address;
            EX_MEM_WriteData   = C1_WriteData;
            EX_MEM_MemRead     = C1_MemRead & ~C1_MemWrite;
            EX_MEM_MemWrite    = C1_MemWrite;
            EX_MEM_HalfControl = C1_HalfControl;
            EX_MEM_ByteControl = C1_ByteControl;
        end
    end

    // Ownership FSM, round-robin pointer and lock hold counter
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= c_ST_IDLE;
            r_ptr   <= 1'b0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_hold <= '0;
                    // The winner was r_ptr, so the loser is ~r_ptr
                    if (w_contended) begin
                        r_ptr <= ~r_ptr;
                    end
                    if (w_win[0] && w_lock[0]) begin
                        r_state <= c_ST_OWN0;
                    end else if (w_win[1] && w_lock[1]) begin
                        r_state <= c_ST_OWN1;
                    end
                end
                c_ST_OWN0: begin
                    if (w_timeout) begin
                        r_state <= c_ST_IDLE;
                        r_ptr   <= 1'b1;
                        r_hold  <= '0;
                    end else if (!w_lock[0]) begin
                        r_state <= c_ST_IDLE;
                        r_hold  <= '0;
                    end else begin
                        r_hold  <= w_hold_inc[3:0];
                    end
                end
                c_ST_OWN1: begin
                    if (w_timeout) begin
                        r_state <= c_ST_IDLE;
                        r_ptr   <= 1'b0;
                        r_hold  <= '0;
                    end else if (!w_lock[1]) begin
                        r_state <= c_ST_IDLE;
                        r_hold  <= '0;
                    end else begin
                        r_hold  <= w_hold_inc[3:0];
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_hold  <= '0;
                end
            endcase
        end
    end

    // Read return path and access counters, one slot per core
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_read_data  <= '0;
            r_read_valid <= '0;
            r_access_cnt <= '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                r_read_valid[k] <= w_rd_grant[k];
                if (w_rd_grant[k]) begin
                    r_read_data[k] <= MEM_ReadData;
                end
                if (w_win[k] && (r_access_cnt[k] != c_CNT_MAX)) begin
                    r_access_cnt[k] <= r_access_cnt[k] + 16'd1;
                end
            end
        end
    end

    assign C0_ReadData    = r_read_data[0];
    assign C1_ReadData    = r_read_data[1];
    assign C0_ReadValid   = r_read_valid[0];
    assign C1_ReadValid   = r_read_valid[1];
    assign C0_AccessCount = r_access_cnt[0];
    assign C1_AccessCount = r_access_cnt[1];

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. It runs directed scenarios
//            and a randomized run against a behavioural ownership model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int c_TIMEOUT = 15;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] C0_Address, C0_WriteData, C1_Address, C1_WriteData;
    logic        C0_MemRead, C0_MemWrite, C0_HalfControl, C0_ByteControl, C0_Lock;
    logic        C1_MemRead, C1_MemWrite, C1_HalfControl, C1_ByteControl, C1_Lock;
    logic        C0_Stall, C1_Stall, C0_ReadValid, C1_ReadValid;
    logic [31:0] C0_ReadData, C1_ReadData;
    logic [15:0] C0_AccessCount, C1_AccessCount;
    logic [31:0] EX_MEM_Address, EX_MEM_WriteData, MEM_ReadData;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    mem_arbiter #(.LOCK_TIMEOUT(c_TIMEOUT)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .C0_Address(C0_Address), .C0_WriteData(C0_WriteData),
        .C0_MemRead(C0_MemRead), .C0_MemWrite(C0_MemWrite),
        .C0_HalfControl(C0_HalfControl), .C0_ByteControl(C0_ByteControl),
        .C0_Lock(C0_Lock), .C0_Stall(C0_Stall), .C0_ReadData(C0_ReadData),
        .C0_ReadValid(C0_ReadValid), .C0_AccessCount(C0_AccessCount),
        .C1_Address(C1_Address), .C1_WriteData(C1_WriteData),
        .C1_MemRead(C1_MemRead), .C1_MemWrite(C1_MemWrite),
        .C1_HalfControl(C1_HalfControl), .C1_ByteControl(C1_ByteControl),
        .C1_Lock(C1_Lock), .C1_Stall(C1_Stall), .C1_ReadData(C1_ReadData),
        .C1_ReadValid(C1_ReadValid), .C1_AccessCount(C1_AccessCount),
        .EX_MEM_Address(EX_MEM_Address), .EX_MEM_WriteData(EX_MEM_WriteData),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_HalfControl(EX_MEM_HalfControl), .EX_MEM_ByteControl(EX_MEM_ByteControl),
        .MEM_ReadData(MEM_ReadData)
    );

    task automatic set_core(input int k, input bit rd, input bit wr, input bit lk,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input bit hf, input bit by);
        if (k == 0) begin
            C0_MemRead = rd; C0_MemWrite = wr; C0_Lock = lk; C0_Address = addr;
            C0_WriteData = wd; C0_HalfControl = hf; C0_ByteControl = by;
        end else begin
            C1_MemRead = rd; C1_MemWrite = wr; C1_Lock = lk; C1_Address = addr;
            C1_WriteData = wd; C1_HalfControl = hf; C1_ByteControl = by;
        end
    endtask

    task automatic clear_all();
        set_core(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        set_core(1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        clear_all();
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_all();
        MEM_ReadData = 32'hFFFF_FFFF;
        Reset_n = 1'b0;
        @(posedge Clk);
        #1;
        set_core(0, 1, 0, 1, 32'h100, 32'h11, 1, 0);
        set_core(1, 0, 1, 1, 32'h200, 32'h22, 0, 1);
        #1;
        checks++;
        if ({C0_Stall, C1_Stall, C0_ReadValid, C1_ReadValid} !== 4'b0) begin
            errors++; $display("FAIL reset_stall_valid: got %b expected 0000", {C0_Stall, C1_Stall, C0_ReadValid, C1_ReadValid});
        end
        checks++;
        if ({EX_MEM_Address, EX_MEM_WriteData} !== 64'h0) begin
            errors++; $display("FAIL reset_exmem_data: got %h expected 0", {EX_MEM_Address, EX_MEM_WriteData});
        end
        checks++;
        if ({EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl} !== 4'b0) begin
            errors++; $display("FAIL reset_exmem_ctl: got %b expected 0000", {EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl});
        end
        checks++;
        if ({C0_ReadData, C1_ReadData, C0_AccessCount, C1_AccessCount} !== 96'h0) begin
            errors++; $display("FAIL reset_regs: got %h expected 0", {C0_ReadData, C1_ReadData, C0_AccessCount, C1_AccessCount});
        end
        clear_all();
        @(posedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    task automatic test_single_read();
        next_cycle();
        set_core(0, 1, 0, 0, 32'h100, 32'h0, 0, 0);
        MEM_ReadData = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({C0_Stall, EX_MEM_Address, EX_MEM_MemRead, EX_MEM_MemWrite} !== {1'b0, 32'h100, 1'b1, 1'b0}) begin
            errors++; $display("FAIL single_read_grant: got stall=%b addr=%h rd=%b wr=%b expected 0 100 1 0", C0_Stall, EX_MEM_Address, EX_MEM_MemRead, EX_MEM_MemWrite);
        end
        next_cycle();
        clear_all();
        MEM_ReadData = 32'h0BAD_F00D;
        #1;
        checks++;
        if ({C0_ReadValid, C0_ReadData, C1_ReadValid} !== {1'b1, 32'hDEAD_BEEF, 1'b0}) begin
            errors++; $display("FAIL single_read_data: got v=%b d=%h v1=%b expected 1 deadbeef 0", C0_ReadValid, C0_ReadData, C1_ReadValid);
        end
        checks++;
        if (C0_AccessCount !== 16'd1) begin
            errors++; $display("FAIL single_read_count: got %0d expected 1", C0_AccessCount);
        end
        next_cycle();
        #1;
        checks++;
        if ({C0_ReadValid, C0_ReadData} !== {1'b0, 32'hDEAD_BEEF}) begin
            errors++; $display("FAIL single_read_hold: got v=%b d=%h expected 0 deadbeef", C0_ReadValid, C0_ReadData);
        end
    endtask

    task automatic test_contention();
        next_cycle();
        set_core(0, 1, 0, 0, 32'h200, 32'h0, 0, 0);
        set_core(1, 1, 0, 0, 32'h300, 32'h0, 0, 0);
        MEM_ReadData = 32'hA0A0_0200;
        #1;
        checks++;
        if ({C0_Stall, C1_Stall, EX_MEM_Address} !== {2'b01, 32'h200}) begin
            errors++; $display("FAIL contend_first: got stalls=%b addr=%h expected 01 200", {C0_Stall, C1_Stall}, EX_MEM_Address);
        end
        next_cycle();
        set_core(0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
        MEM_ReadData = 32'hB1B1_0300;
        #1;
        checks++;
        if ({C0_Stall, C1_Stall, EX_MEM_Address} !== {2'b00, 32'h300}) begin
            errors++; $display("FAIL contend_second: got stalls=%b addr=%h expected 00 300", {C0_Stall, C1_Stall}, EX_MEM_Address);
        end
        checks++;
        if ({C0_ReadValid, C0_ReadData} !== {1'b1, 32'hA0A0_0200}) begin
            errors++; $display("FAIL contend_c0_data: got v=%b d=%h expected 1 a0a00200", C0_ReadValid, C0_ReadData);
        end
        next_cycle();
        clear_all();
        #1;
        checks++;
        if ({C1_ReadValid, C1_ReadData, C0_AccessCount, C1_AccessCount} !== {1'b1, 32'hB1B1_0300, 16'd2, 16'd1}) begin
            errors++; $display("FAIL contend_c1_data: got v=%b d=%h cnt0=%0d cnt1=%0d expected 1 b1b10300 2 1", C1_ReadValid, C1_ReadData, C0_AccessCount, C1_AccessCount);
        end
    endtask

    task automatic test_write_passthrough();
        next_cycle();
        set_core(0, 1, 1, 0, 32'h0000_0402, 32'h0000_55AA, 1, 0);
        #1;
        checks++;
        if ({EX_MEM_Address, EX_MEM_WriteData, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl}
            !== {32'h0000_0402, 32'h0000_55AA, 4'b0110}) begin
            errors++; $display("FAIL write_both_strobes: got addr=%h wd=%h ctl=%b expected 402 55aa 0110", EX_MEM_Address, EX_MEM_WriteData, {EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl});
        end
        next_cycle();
        clear_all();
        set_core(1, 0, 1, 0, 32'h0000_0513, 32'h0000_0077, 0, 1);
        #1;
        checks++;
        if ({C0_ReadValid, C0_ReadData} !== {1'b0, 32'hA0A0_0200}) begin
            errors++; $display("FAIL write_no_valid: got v=%b d=%h expected 0 a0a00200", C0_ReadValid, C0_ReadData);
        end
        checks++;
        if ({EX_MEM_Address, EX_MEM_WriteData, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl}
            !== {32'h0000_0513, 32'h0000_0077, 4'b0101}) begin
            errors++; $display("FAIL write_byte_c1: got addr=%h wd=%h ctl=%b expected 513 77 0101", EX_MEM_Address, EX_MEM_WriteData, {EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl});
        end
        next_cycle();
        clear_all();
        #1;
        checks++;
        if ({C0_Stall, C1_Stall, EX_MEM_Address, EX_MEM_MemRead, EX_MEM_MemWrite} !== 36'h0) begin
            errors++; $display("FAIL idle_outputs: got stalls=%b addr=%h rd=%b wr=%b expected all 0", {C0_Stall, C1_Stall}, EX_MEM_Address, EX_MEM_MemRead, EX_MEM_MemWrite);
        end
    endtask

    // Pointer is 1 here (left by the contention scenario), so core 1 wins the
    // first contended cycle and then keeps core 0 out while it owns the memory.
    task automatic test_lock();
        logic [3:0]  exp_flags;
        logic [31:0] exp_addr;
        for (int c = 0; c < 5; c++) begin
            next_cycle();
            if (c < 3) set_core(1, 0, 1, 1, 32'h500 + 32'(4 * c), 32'(c), 0, 0);
            else       set_core(1, 0, 0, 0, 32'h0, 32'h0, 0, 0);
            set_core(0, 1, 0, 0, 32'h600, 32'h0, 0, 0);
            #1;
            exp_flags = {(c < 4), 1'b0, (c < 3), (c == 4)};
            exp_addr  = (c < 3) ? 32'h500 + 32'(4 * c) : ((c == 4) ? 32'h600 : 32'h0);
            checks++;
            if ({C0_Stall, C1_Stall, EX_MEM_MemWrite, EX_MEM_MemRead, EX_MEM_Address} !== {exp_flags, exp_addr}) begin
                errors++; $display("FAIL lock_cycle%0d: got flags=%b addr=%h expected flags=%b addr=%h", c, {C0_Stall, C1_Stall, EX_MEM_MemWrite, EX_MEM_MemRead}, EX_MEM_Address, exp_flags, exp_addr);
            end
        end
        next_cycle();
        clear_all();
    endtask

    // Core 0 starts alone (pointer stays 0); only the timeout can hand the
    // pointer to core 1 for the cycle right after 15 owned cycles.
    task automatic test_timeout();
        logic [1:0] exp_stall;
        for (int c = 0; c <= 20; c++) begin
            next_cycle();
            set_core(0, (c < 20), 0, (c < 20), 32'h700, 32'h0, 0, 0);
            set_core(1, (c >= 1 && c <= 16), 0, 0, 32'h800, 32'h0, 0, 0);
            #1;
            exp_stall = {(c == 16), (c >= 1 && c <= 15)};
            checks++;
            if ({C0_Stall, C1_Stall} !== exp_stall) begin
                errors++; $display("FAIL timeout_cycle%0d: got stalls=%b expected %b", c, {C0_Stall, C1_Stall}, exp_stall);
            end
        end
        next_cycle();
        clear_all();
        set_core(1, 1, 0, 0, 32'h804, 32'h0, 0, 0);
        #1;
        checks++;
        if ({C1_Stall, EX_MEM_Address} !== {1'b0, 32'h804}) begin
            errors++; $display("FAIL timeout_after: got stall=%b addr=%h expected 0 804", C1_Stall, EX_MEM_Address);
        end
        next_cycle();
        clear_all();
    endtask

    // Random traffic against an ownership model: owner -1 = nobody, otherwise
    // the locking core; held counts cycles spent owning.
    task automatic test_random();
        int owner, ptr, held, g;
        int cnt[2];
        logic [31:0] exp_rd[2], ad[2], wd[2];
        bit exp_rv[2], rd[2], wr[2], lk[2], hf[2], by[2], req[2];
        logic [31:0] mem, exp_addr, exp_wd;
        logic [3:0]  exp_ctl;
        logic [1:0]  exp_stall;
        int op;
        apply_reset();
        owner = -1; ptr = 0; held = 0;
        for (int k = 0; k < 2; k++) begin
            cnt[k] = 0; exp_rd[k] = '0; exp_rv[k] = 0; lk[k] = 0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            next_cycle();
            for (int k = 0; k < 2; k++) begin
                op = int'($urandom_range(0, 4));
                rd[k] = (op == 1 || op == 3);
                wr[k] = (op == 2 || op == 3 || op == 4);
                if ($urandom_range(0, 7) == 0) lk[k] = ~lk[k];
                ad[k] = $urandom; wd[k] = $urandom;
                hf[k] = 1'($urandom); by[k] = 1'($urandom);
                req[k] = rd[k] | wr[k];
                set_core(k, rd[k], wr[k], lk[k], ad[k], wd[k], hf[k], by[k]);
            end
            mem = $urandom;
            MEM_ReadData = mem;
            #1;
            g = -1;
            if (owner < 0) begin
                if (req[0] && req[1]) g = ptr;
                else if (req[0])      g = 0;
                else if (req[1])      g = 1;
            end else if (req[owner]) begin
                g = owner;
            end
            exp_stall = {req[0] && g != 0, req[1] && g != 1};
            exp_addr  = (g >= 0) ? ad[g] : 32'h0;
            exp_wd    = (g >= 0) ? wd[g] : 32'h0;
            exp_ctl   = (g >= 0) ? {rd[g] & ~wr[g], wr[g], hf[g], by[g]} : 4'b0;
            checks++;
            if ({C0_Stall, C1_Stall} !== exp_stall) begin
                errors++; $display("FAIL rand_stall cyc%0d: got %b expected %b", cyc, {C0_Stall, C1_Stall}, exp_stall);
            end
            checks++;
            if ({EX_MEM_Address, EX_MEM_WriteData, EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl}
                !== {exp_addr, exp_wd, exp_ctl}) begin
                errors++; $display("FAIL rand_exmem cyc%0d: got %h %h %b expected %h %h %b", cyc, EX_MEM_Address, EX_MEM_WriteData, {EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_HalfControl, EX_MEM_ByteControl}, exp_addr, exp_wd, exp_ctl);
            end
            checks++;
            if ({C0_ReadValid, C0_ReadData, C1_ReadValid, C1_ReadData} !== {exp_rv[0], exp_rd[0], exp_rv[1], exp_rd[1]}) begin
                errors++; $display("FAIL rand_read cyc%0d: got %b %h %b %h expected %b %h %b %h", cyc, C0_ReadValid, C0_ReadData, C1_ReadValid, C1_ReadData, exp_rv[0], exp_rd[0], exp_rv[1], exp_rd[1]);
            end
            checks++;
            if ({C0_AccessCount, C1_AccessCount} !== {16'(cnt[0]), 16'(cnt[1])}) begin
                errors++; $display("FAIL rand_count cyc%0d: got %0d %0d expected %0d %0d", cyc, C0_AccessCount, C1_AccessCount, cnt[0], cnt[1]);
            end
            // Advance the model across the coming rising edge
            for (int k = 0; k < 2; k++) begin
                exp_rv[k] = (g == k) && rd[k] && !wr[k];
                if (exp_rv[k]) exp_rd[k] = mem;
            end
            if (g >= 0 && cnt[g] < 65535) cnt[g]++;
            if (owner < 0) begin
                if (req[0] && req[1]) ptr = 1 - g;
                if (g >= 0 && lk[g]) begin
                    owner = g;
                    held  = 0;
                end
            end else begin
                held++;
                if (held >= c_TIMEOUT) begin
                    ptr   = 1 - owner;
                    owner = -1;
                end else if (!lk[owner]) begin
                    owner = -1;
                end
            end
        end
        next_cycle();
        clear_all();
    endtask

    task automatic test_saturation();
        apply_reset();
        next_cycle();
        set_core(0, 1, 0, 0, 32'h40, 32'h0, 0, 0);
        repeat (65533) @(posedge Clk);
        #1;
        checks++;
        if ({C0_AccessCount, C1_AccessCount} !== {16'hFFFD, 16'h0}) begin
            errors++; $display("FAIL sat_preload: got %h %h expected fffd 0000", C0_AccessCount, C1_AccessCount);
        end
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (C0_AccessCount !== 16'hFFFF) begin
            errors++; $display("FAIL sat_limit: got %h expected ffff", C0_AccessCount);
        end
        repeat (2) @(posedge Clk);
        #1;
        checks++;
        if (C0_AccessCount !== 16'hFFFF) begin
            errors++; $display("FAIL sat_hold: got %h expected ffff", C0_AccessCount);
        end
        clear_all();
    endtask

    task automatic test_reset_mid_lock();
        next_cycle();
        clear_all();
        set_core(1, 0, 1, 1, 32'h900, 32'h99, 0, 0);
        #1;
        checks++;
        if (C1_Stall !== 1'b0) begin
            errors++; $display("FAIL rml_lock_grant: got %b expected 0", C1_Stall);
        end
        next_cycle();
        set_core(1, 1, 0, 1, 32'h904, 32'h0, 0, 0);
        set_core(0, 1, 0, 0, 32'hA00, 32'h0, 0, 0);
        MEM_ReadData = 32'h1234_5678;
        #1;
        checks++;
        if ({C0_Stall, C1_Stall} !== 2'b10) begin
            errors++; $display("FAIL rml_owned: got %b expected 10", {C0_Stall, C1_Stall});
        end
        #2 Reset_n = 1'b0;
        #1;
        checks++;
        if ({C0_Stall, C1_Stall, C0_ReadValid, C1_ReadValid, EX_MEM_MemRead, EX_MEM_Address} !== 37'h0) begin
            errors++; $display("FAIL rml_async: got flags=%b addr=%h expected all 0", {C0_Stall, C1_Stall, C0_ReadValid, C1_ReadValid, EX_MEM_MemRead}, EX_MEM_Address);
        end
        checks++;
        if ({C0_AccessCount, C1_AccessCount} !== 32'h0) begin
            errors++; $display("FAIL rml_counts: got %h %h expected 0 0", C0_AccessCount, C1_AccessCount);
        end
        @(posedge Clk);
        #1;
        set_core(1, 1, 0, 0, 32'h908, 32'h0, 0, 0);
        MEM_ReadData = 32'h0F0F_0F0F;
        Reset_n = 1'b1;
        #1;
        checks++;
        if ({C0_Stall, C1_Stall, C1_ReadValid, C1_ReadData} !== {2'b01, 1'b0, 32'h0}) begin
            errors++; $display("FAIL rml_release: got stalls=%b v1=%b d1=%h expected 01 0 0", {C0_Stall, C1_Stall}, C1_ReadValid, C1_ReadData);
        end
        next_cycle();
        clear_all();
        #1;
        checks++;
        if ({C0_ReadValid, C0_ReadData, C1_ReadValid} !== {1'b1, 32'h0F0F_0F0F, 1'b0}) begin
            errors++; $display("FAIL rml_after: got v0=%b d0=%h v1=%b expected 1 0f0f0f0f 0", C0_ReadValid, C0_ReadData, C1_ReadValid);
        end
    endtask

    initial begin
        clear_all();
        MEM_ReadData = 32'h0;
        test_reset();
        test_single_read();
        test_contention();
        test_write_passthrough();
        test_lock();
        test_timeout();
        test_random();
        test_saturation();
        test_reset_mid_lock();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got time limit expected completion");
        $fatal(1, "time limit reached");
    end

endmodule
`default_nettype wire
